// File: rtl/ariane_pkg.sv
// Shared types for the performance-event collector: functional-unit and
// operation encodings, the committing scoreboard entry, raw event sources,
// the mhpmevent slot encoding and the commit-class one-hot layout.
package ariane_pkg;

    localparam int unsigned PERF_INC_W       = 2;
    localparam int unsigned DCACHE_SET_ASSOC = 8;

    typedef enum logic [3:0] {
        NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
    } fu_t;

    typedef enum logic [7:0] {
        ADD, SUB, JALR, EQ, LW, SW, MUL, FADD
    } fu_op;

    typedef struct packed {
        fu_t        fu;
        fu_op       op;
        logic [4:0] rd;
    } scoreboard_entry_t;

    // Single-bit event sources gathered from around the core.
    typedef struct packed {
        logic icache_miss;
        logic dcache_miss;
        logic itlb_miss;
        logic dtlb_miss;
        logic ex_valid;
        logic eret;
        logic mispredict;
        logic branch_ex;
        logic sb_full;
        logic if_empty;
        logic icache_req;
        logic itlb_flush;
        logic issue_stall;
    } perf_raw_evt_t;

    // Slot numbers double as the mhpmevent selector values.
    typedef enum logic [4:0] {
        EV_NONE         = 5'd0,
        EV_ICACHE_MISS  = 5'd1,
        EV_DCACHE_MISS  = 5'd2,
        EV_ITLB_MISS    = 5'd3,
        EV_DTLB_MISS    = 5'd4,
        EV_LOAD         = 5'd5,
        EV_STORE        = 5'd6,
        EV_EXCEPTION    = 5'd7,
        EV_ERET         = 5'd8,
        EV_BRANCH       = 5'd9,
        EV_MISPREDICT   = 5'd10,
        EV_BRANCH_EX    = 5'd11,
        EV_CALL         = 5'd12,
        EV_RETURN       = 5'd13,
        EV_SB_FULL      = 5'd14,
        EV_IF_EMPTY     = 5'd15,
        EV_ICACHE_ACC   = 5'd16,
        EV_DCACHE_ACC   = 5'd17,
        EV_EVICTION     = 5'd18,
        EV_ITLB_FLUSH   = 5'd19,
        EV_INT_INSTR    = 5'd20,
        EV_FP_INSTR     = 5'd21,
        EV_BUBBLE       = 5'd22
    } perf_event_e;

    // Bit positions inside the per-port one-hot commit class vector.
    localparam int unsigned CLS_LOAD   = 0;
    localparam int unsigned CLS_STORE  = 1;
    localparam int unsigned CLS_BRANCH = 2;
    localparam int unsigned CLS_CALL   = 3;
    localparam int unsigned CLS_RET    = 4;
    localparam int unsigned CLS_INT    = 5;
    localparam int unsigned CLS_FP     = 6;
    localparam int unsigned NR_CLASSES = 7;

    // Add two increments, clamping at the all-ones maximum instead of wrapping.
    function automatic logic [PERF_INC_W-1:0] sat_add(input logic [PERF_INC_W-1:0] a,
                                                      input logic [PERF_INC_W-1:0] b);
        logic [PERF_INC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PERF_INC_W] ? {PERF_INC_W{1'b1}} : s[PERF_INC_W-1:0];
    endfunction

endpackage

// File: rtl/perf_event_collector_classify.sv
// Classifies one commit port into at most one event class. Calls and returns
// take priority over the generic branch class so that a jump is counted once.
module perf_commit_classify
    import ariane_pkg::*;
(
    input  scoreboard_entry_t       instr_i,
    input  logic                    ack_i,
    output logic [NR_CLASSES-1:0]   class_o
);

    logic is_call;
    logic is_ret;

    // Decode the committing entry into a one-hot class (all-zero if not acked).
    always_comb begin
        class_o = '0;
        is_call = (instr_i.fu == CTRL_FLOW) && (instr_i.op == ADD || instr_i.op == JALR) &&
                  (instr_i.rd == 5'd1 || instr_i.rd == 5'd5);
        is_ret  = (instr_i.op == JALR) && (instr_i.rd == 5'd0);
        if (ack_i) begin
            if (is_call)                                       class_o[CLS_CALL]   = 1'b1;
            else if (is_ret)                                   class_o[CLS_RET]    = 1'b1;
            else if (instr_i.fu == CTRL_FLOW)                  class_o[CLS_BRANCH] = 1'b1;
            else if (instr_i.fu == LOAD)                       class_o[CLS_LOAD]   = 1'b1;
            else if (instr_i.fu == STORE)                      class_o[CLS_STORE]  = 1'b1;
            else if (instr_i.fu == ALU || instr_i.fu == MULT)  class_o[CLS_INT]    = 1'b1;
            else if (instr_i.fu == FPU || instr_i.fu == FPU_VEC) class_o[CLS_FP]   = 1'b1;
        end
    end

endmodule

// File: rtl/perf_event_collector.sv
// Collects per-cycle performance events into registered per-slot increments.
// Optional build macro PERF_EDGE_DETECT_EN: cache/TLB miss slots count only
// rising edges of their source instead of every high cycle.
module perf_event_collector
    import ariane_pkg::*;
#(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned NumEvents     = 23
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        debug_mode_i,
    input  logic                                        inhibit_i,
    input  scoreboard_entry_t [NrCommitPorts-1:0]       commit_instr_i,
    input  logic [NrCommitPorts-1:0]                    commit_ack_i,
    input  perf_raw_evt_t                               raw_evt_i,
    input  logic [2:0]                                  dcache_req_i,
    input  logic [2:0][DCACHE_SET_ASSOC-1:0]            miss_vld_bits_i,
    output logic [NumEvents-1:0][PERF_INC_W-1:0]        event_inc_o,
    output logic                                        event_any_o
);

    logic [NrCommitPorts-1:0][NR_CLASSES-1:0] port_class;
    logic [NR_CLASSES-1:0][PERF_INC_W-1:0]    class_cnt;
    logic [3:0]                               miss_lvl;
    logic [3:0]                               miss_evt;
    logic                                     evict;
    logic [PERF_INC_W-1:0]                    dreq_cnt;
    logic [NumEvents-1:0][PERF_INC_W-1:0]     inc_d;

    for (genvar p = 0; p < NrCommitPorts; p++) begin : g_classify
        perf_commit_classify u_classify (
            .instr_i (commit_instr_i[p]),
            .ack_i   (commit_ack_i[p]),
            .class_o (port_class[p])
        );
    end

    // Count, per class, how many acknowledged ports fall into it.
    always_comb begin
        class_cnt = '0;
        for (int c = 0; c < NR_CLASSES; c++) begin
            for (int p = 0; p < NrCommitPorts; p++) begin
                class_cnt[c] = sat_add(class_cnt[c], {{(PERF_INC_W-1){1'b0}}, port_class[p][c]});
            end
        end
    end

    assign miss_lvl = {raw_evt_i.dtlb_miss, raw_evt_i.itlb_miss,
                       raw_evt_i.dcache_miss, raw_evt_i.icache_miss};

`ifdef PERF_EDGE_DETECT_EN
    logic [3:0] miss_hist_q;

    // Previous level of each miss source; keeps tracking even while counting is frozen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) miss_hist_q <= '0;
        else         miss_hist_q <= miss_lvl;
    end

    assign miss_evt = miss_lvl & ~miss_hist_q;
`else
    assign miss_evt = miss_lvl;
`endif

    // A miss into a set whose ways are all valid must evict a line.
    always_comb begin
        evict = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (&miss_vld_bits_i[i]) evict = 1'b1;
        end
        evict = evict & raw_evt_i.dcache_miss;
    end

    assign dreq_cnt = PERF_INC_W'(dcache_req_i[0]) + PERF_INC_W'(dcache_req_i[1]) +
                      PERF_INC_W'(dcache_req_i[2]);

    // Assemble the next increment vector; debug mode and inhibit zero every slot.
    always_comb begin
        inc_d = '0;
        if (!(debug_mode_i || inhibit_i)) begin
            inc_d[EV_ICACHE_MISS] = PERF_INC_W'(miss_evt[0]);
            inc_d[EV_DCACHE_MISS] = PERF_INC_W'(miss_evt[1]);
            inc_d[EV_ITLB_MISS]   = PERF_INC_W'(miss_evt[2]);
            inc_d[EV_DTLB_MISS]   = PERF_INC_W'(miss_evt[3]);
            inc_d[EV_LOAD]        = class_cnt[CLS_LOAD];
            inc_d[EV_STORE]       = class_cnt[CLS_STORE];
            inc_d[EV_EXCEPTION]   = PERF_INC_W'(raw_evt_i.ex_valid);
            inc_d[EV_ERET]        = PERF_INC_W'(raw_evt_i.eret);
            inc_d[EV_BRANCH]      = class_cnt[CLS_BRANCH];
            inc_d[EV_MISPREDICT]  = PERF_INC_W'(raw_evt_i.mispredict);
            inc_d[EV_BRANCH_EX]   = PERF_INC_W'(raw_evt_i.branch_ex);
            inc_d[EV_CALL]        = class_cnt[CLS_CALL];
            inc_d[EV_RETURN]      = class_cnt[CLS_RET];
            inc_d[EV_SB_FULL]     = PERF_INC_W'(raw_evt_i.sb_full);
            inc_d[EV_IF_EMPTY]    = PERF_INC_W'(raw_evt_i.if_empty);
            inc_d[EV_ICACHE_ACC]  = PERF_INC_W'(raw_evt_i.icache_req);
            inc_d[EV_DCACHE_ACC]  = dreq_cnt;
            inc_d[EV_EVICTION]    = PERF_INC_W'(evict);
            inc_d[EV_ITLB_FLUSH]  = PERF_INC_W'(raw_evt_i.itlb_flush);
            inc_d[EV_INT_INSTR]   = class_cnt[CLS_INT];
            inc_d[EV_FP_INSTR]    = class_cnt[CLS_FP];
            inc_d[EV_BUBBLE]      = PERF_INC_W'(raw_evt_i.issue_stall);
        end
    end

    // Output register: one cycle of latency from sampled inputs to increments.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            event_inc_o <= '0;
            event_any_o <= 1'b0;
        end else begin
            event_inc_o <= inc_d;
            event_any_o <= |inc_d;
        end
    end

endmodule

// File: doc/perf_event_collector.md
PERF_EVENT_COLLECTOR -- requirements
Module: perf_event_collector

Interface
REQ-001 SHALL have parameter NrCommitPorts, default 2, commit ports observed (legal 1..3).
REQ-002 SHALL have parameter NumEvents, default 23, event slots indexed 0..22; slot 0 is the "no event" slot and is always 0.
REQ-003 SHALL have port clk_i  in  1  clock; reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-004 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have port debug_mode_i  in  1  core in debug mode; all increments are suppressed.
REQ-006 SHALL have port inhibit_i  in  1  global count freeze from the CSR file.
REQ-007 SHALL have port commit_instr_i  in  NrCommitPorts x scoreboard_entry_t  committing instructions.
REQ-008 SHALL have port commit_ack_i  in  NrCommitPorts  per-port commit acknowledge.
REQ-009 SHALL have port raw_evt_i  in  perf_raw_evt_t  single-bit sources: I$/D$ miss, ITLB/DTLB miss, exception valid, eret, mispredict, branch exception, SB full, IF empty, I$ req, ITLB flush, issue stall.
REQ-010 SHALL have port dcache_req_i  in  3  data_req of D$ ports 0..2.
REQ-011 SHALL have port miss_vld_bits_i  in  3 x DCACHE_SET_ASSOC  valid bits of the set targeted by each miss port.
REQ-012 SHALL have port event_inc_o  out  NumEvents x 2  registered per-event increment, 0..3.
REQ-013 SHALL have port event_any_o  out  1  OR-reduction of all event_inc_o slots being non-zero.

Function
REQ-014 SHALL register all outputs; stimulus sampled at edge N SHALL appear on event_inc_o after edge N+1 (latency 1).
REQ-015 SHALL drive slot codes exactly as perf_event_e (1 I$ miss .. 22 pipeline bubbles), matching the mhpmevent selector encoding.
REQ-016 Commit-class slots (load, store, branch, call, return, integer, FP) SHALL carry the number of ports with commit_ack_i=1 whose entry matches the class; ports with ack=0 are ignored.
REQ-017 Call SHALL be fu==CTRL_FLOW, op in {ADD,JALR}, rd in {x1,x5}; return SHALL be op==JALR with rd==x0.
REQ-018 The D$-access slot SHALL carry popcount(dcache_req_i) (0..3).
REQ-019 The eviction slot SHALL be 1 when the D$ miss is asserted and any port's miss_vld_bits_i is all ones, never more than 1.
REQ-020 All remaining slots SHALL be 0 or 1.
REQ-021 When debug_mode_i or inhibit_i is sampled high at edge N, all slots SHALL be 0 after edge N+1; internal edge history SHALL still update.
REQ-022 Slot arithmetic SHALL saturate at 3; no wrap.

Reset
REQ-023 On rst_ni low, event_inc_o and event_any_o SHALL be 0 and the edge history SHALL be 0, asynchronously.
REQ-024 The first sampling edge after reset release SHALL treat the edge history as 0 (a level already high counts as an edge).

Configuration
REQ-025 With PERF_EDGE_DETECT_EN defined, the I$-miss, D$-miss, ITLB-miss and DTLB-miss slots SHALL be 1 only on a 0->1 transition of the source (one flop of history per source).
REQ-026 Without PERF_EDGE_DETECT_EN, those slots SHALL be 1 in every cycle the source is high, and no history flops SHALL exist.

Structure
REQ-027 perf_event_e, perf_raw_evt_t and the constant PERF_INC_W=2 SHALL live in ariane_pkg.
REQ-028 Commit-port classification SHALL be a sub-module perf_commit_classify, instantiated once per port, giving a one-hot class vector.

Verification
REQ-029 Two ports ack'd, both fu=LOAD -> load slot =2 one cycle later; only port 1 ack'd -> 1.
REQ-030 dcache_req_i=3'b111 -> D$-access slot =3; 3'b010 -> 1.
REQ-031 PERF_EDGE_DETECT_EN set, D$ miss high for 5 cycles -> D$-miss slot =1 for exactly one cycle; unset -> 1 for 5 cycles.
REQ-032 inhibit_i high across a rising ITLB miss, then low with the miss still high -> ITLB slot stays 0 throughout (edge-detect build).
REQ-033 Port 0 commits JALR rd=x1, port 1 commits JALR rd=x0 -> call=1, return=1, branch=0 (fu not CTRL_FLOW for both unless set).
REQ-034 Reset asserted mid-burst with all sources high -> all outputs 0 immediately; after release, edge-detected slots report 1 on the first cycle.
